// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states
// and the datapath mux select values.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that drive a memory strobe and may stretch on slow memory
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for memory states; built only when MC_MEM_WAIT_EN is defined.
// expired is high in the MAX_WAIT-th consecutive waiting cycle.
`ifdef MC_MEM_WAIT_EN
module mem_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] count_r;

   assign expired = enable & (count_r == CW'(MAX_WAIT - 1));

   // Count waiting cycles; restart on leaving the wait or on expiry
   always_ff @(posedge clk) begin
      if (reset || clear || expired) begin
         count_r <= {CW{1'b0}};
      end else if (enable) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule
`endif

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM. Optional wait-state handshake on FETCH/MEMRD/MEMWR
// is enabled by defining MC_MEM_WAIT_EN.
module mips_mc_control
   import mips_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ir_en,
   output logic       mdr_en,
   output logic       ab_en,
   output logic       aluout_en,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   state_t state_r, next_s;
   logic   ready_s, timeout_s;

`ifdef MC_MEM_WAIT_EN
   logic wait_s, expired_s;

   assign ready_s   = mem_ready;
   assign wait_s    = is_mem_state(state_r) & ~mem_ready;
   assign timeout_s = expired_s;

   mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (~wait_s),
      .enable  (wait_s),
      .expired (expired_s)
   );
`else
   logic unused_s;

   assign ready_s   = 1'b1;
   assign timeout_s = 1'b0;
   assign unused_s  = mem_ready & (MAX_WAIT > 0);
`endif

   assign state = state_r;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state and output decode; everything held low while reset is asserted
   always_comb begin
      next_s      = state_r;
      pc_en       = 1'b0;
      ir_en       = 1'b0;
      mdr_en      = 1'b0;
      ab_en       = 1'b0;
      aluout_en   = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_B;
      alu_op      = ALU_ADD;
      pc_src      = PCSRC_ALU;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
      if (reset) begin
         next_s = S_FETCH;
      end else begin
         mem_timeout = timeout_s;
         case (state_r)
            S_FETCH: begin
               mem_read  = 1'b1;
               ir_en     = ready_s;
               pc_en     = ready_s;
               alu_src_b = SRCB_FOUR;
               pc_src    = PCSRC_ALU;
               if (ready_s && !timeout_s) next_s = S_DECODE;
               else                       next_s = S_FETCH;
            end
            S_DECODE: begin
               ab_en     = 1'b1;
               aluout_en = 1'b1;
               alu_src_b = SRCB_IMMSH;
               case (opcode)
                  OP_LW, OP_SW: next_s = S_MEMADR;
                  OP_RTYPE:     next_s = S_EXEC;
                  OP_BEQ:       next_s = S_BRANCH;
                  OP_ADDI:      next_s = S_ADDIEX;
                  OP_J:         next_s = S_JUMP;
                  default: begin
                     next_s     = S_FETCH;
                     illegal_op = 1'b1;
                  end
               endcase
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               aluout_en = 1'b1;
               if (opcode == OP_SW) next_s = S_MEMWR;
               else                 next_s = S_MEMRD;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
               mdr_en   = ready_s;
               if (timeout_s)    next_s = S_FETCH;
               else if (ready_s) next_s = S_MEMWB;
               else              next_s = S_MEMRD;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               next_s     = S_FETCH;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               if (timeout_s || ready_s) next_s = S_FETCH;
               else                      next_s = S_MEMWR;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
               aluout_en = 1'b1;
               next_s    = S_ALUWB;
            end
            S_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               next_s    = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_SUB;
               pc_src    = PCSRC_ALUOUT;
               pc_en     = zero;
               next_s    = S_FETCH;
            end
            S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               aluout_en = 1'b1;
               next_s    = S_ADDIWB;
            end
            S_ADDIWB: begin
               reg_write = 1'b1;
               next_s    = S_FETCH;
            end
            S_JUMP: begin
               pc_src = PCSRC_JUMP;
               pc_en  = 1'b1;
               next_s = S_FETCH;
            end
            default: begin
               next_s = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: directed reset/lw/beq/illegal/reset-mid-store
// steps, optional wait-state steps, then random instructions against a reference model.
module tb_mips_mc_control;
   import mips_pkg::*;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] opcode;
   logic       pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write, mem_read, mem_write;
   logic       iord, reg_dst, mem_to_reg, alu_src_a, illegal_op, mem_timeout;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;
   state_t exp_q[$];

   always #5 clk = ~clk;

   mips_mc_control #(.MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .ir_en(ir_en), .mdr_en(mdr_en), .ab_en(ab_en), .aluout_en(aluout_en),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op),
      .mem_timeout(mem_timeout), .state(state)
   );

   wire [19:0] obs_w = {pc_en, ir_en, mdr_en, ab_en, aluout_en, reg_write, mem_read,
                        mem_write, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                        alu_op, pc_src, illegal_op, mem_timeout};

   // Reference: outputs each step of an instruction must show, straight from the state table
   function automatic logic [19:0] model(input state_t s, input logic [5:0] op, input logic z,
                                         input logic rdy, input logic tmo);
      logic pc, ir, mdr, ab, ao, rw, mr, mw, io, rd, m2r, sa, ill;
      logic [1:0] sb, aop, ps;
      {pc, ir, mdr, ab, ao, rw, mr, mw, io, rd, m2r, sa, ill} = 13'b0;
      sb = 2'b00; aop = 2'b00; ps = 2'b00;
      case (s)
         S_FETCH:  begin mr = 1'b1; ir = rdy; pc = rdy; sb = 2'b01; end
         S_DECODE: begin
            ab = 1'b1; ao = 1'b1; sb = 2'b11;
            ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
         end
         S_MEMADR: begin sa = 1'b1; sb = 2'b10; ao = 1'b1; end
         S_MEMRD:  begin mr = 1'b1; io = 1'b1; mdr = rdy; end
         S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
         S_MEMWR:  begin mw = 1'b1; io = 1'b1; end
         S_EXEC:   begin sa = 1'b1; aop = 2'b10; ao = 1'b1; end
         S_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
         S_BRANCH: begin sa = 1'b1; aop = 2'b01; ps = 2'b01; pc = z; end
         S_ADDIEX: begin sa = 1'b1; sb = 2'b10; ao = 1'b1; end
         S_ADDIWB: begin rw = 1'b1; end
         S_JUMP:   begin ps = 2'b10; pc = 1'b1; end
         default:  begin end
      endcase
      return {pc, ir, mdr, ab, ao, rw, mr, mw, io, rd, m2r, sa, sb, aop, ps, ill, tmo};
   endfunction

   // Reference: the step list of one instruction with no wait states
   task automatic build_seq(input logic [5:0] op);
      exp_q = {S_FETCH, S_DECODE};
      case (op)
         6'b100011: exp_q = {exp_q, S_MEMADR, S_MEMRD, S_MEMWB};
         6'b101011: exp_q = {exp_q, S_MEMADR, S_MEMWR};
         6'b000000: exp_q = {exp_q, S_EXEC, S_ALUWB};
         6'b000100: exp_q = {exp_q, S_BRANCH};
         6'b001000: exp_q = {exp_q, S_ADDIEX, S_ADDIWB};
         6'b000010: exp_q = {exp_q, S_JUMP};
         default:   begin end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input state_t es, input logic [19:0] eo);
      checks++;
      assert (state === es) else begin
         failures++;
         $error("FAIL %s state: got %0d expected %0d", tag, state, es);
      end
      checks++;
      assert (obs_w === eo) else begin
         failures++;
         $error("FAIL %s outputs: got %h expected %h", tag, obs_w, eo);
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic z);
      build_seq(op);
      opcode = op;
      zero   = z;
      foreach (exp_q[i]) begin
         check(tag, exp_q[i], model(exp_q[i], op, z, 1'b1, 1'b0));
         tick();
      end
   endtask

   initial begin
      logic [5:0] op;
      reset = 1'b1; zero = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;

      // Reset held three cycles: everything low, state FETCH
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset", S_FETCH, 20'h0);
      end
      reset = 1'b0;
      #1;
      check("first_fetch", S_FETCH, model(S_FETCH, 6'b0, 1'b0, 1'b1, 1'b0));

      run_instr("lw", OP_LW, 1'b0);
      run_instr("beq_z0", OP_BEQ, 1'b0);
      run_instr("beq_z1", OP_BEQ, 1'b1);
      run_instr("illegal", 6'b111111, 1'b0);
      run_instr("sw", OP_SW, 1'b0);
      run_instr("rtype", OP_RTYPE, 1'b0);
      run_instr("addi", OP_ADDI, 1'b1);
      run_instr("j", OP_J, 1'b0);

      // Reset while a store is in MEMWR
      build_seq(OP_SW);
      opcode = OP_SW;
      for (int i = 0; i < 4; i++) begin
         check("sw_pre_rst", exp_q[i], model(exp_q[i], OP_SW, 1'b0, 1'b1, 1'b0));
         if (i < 3) tick();
      end
      reset = 1'b1;
      tick();
      check("rst_memwr", S_FETCH, 20'h0);
      reset = 1'b0;
      #1;
      check("after_rst", S_FETCH, model(S_FETCH, 6'b0, 1'b0, 1'b1, 1'b0));
      run_instr("lw_after_rst", OP_LW, 1'b0);

`ifdef MC_MEM_WAIT_EN
      // Three waiting cycles in MEMRD, data arrives on the fourth
      opcode = OP_LW;
      check("ws_fetch", S_FETCH, model(S_FETCH, OP_LW, 1'b0, 1'b1, 1'b0)); tick();
      check("ws_dec", S_DECODE, model(S_DECODE, OP_LW, 1'b0, 1'b1, 1'b0)); tick();
      check("ws_adr", S_MEMADR, model(S_MEMADR, OP_LW, 1'b0, 1'b1, 1'b0));
      mem_ready = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         check("ws_wait", S_MEMRD, model(S_MEMRD, OP_LW, 1'b0, 1'b0, 1'b0));
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("ws_ready", S_MEMRD, model(S_MEMRD, OP_LW, 1'b0, 1'b1, 1'b0)); tick();
      check("ws_wb", S_MEMWB, model(S_MEMWB, OP_LW, 1'b0, 1'b1, 1'b0)); tick();

      // Memory never answers: timeout on the 15th waiting cycle, then refetch
      check("to_fetch", S_FETCH, model(S_FETCH, OP_LW, 1'b0, 1'b1, 1'b0)); tick();
      check("to_dec", S_DECODE, model(S_DECODE, OP_LW, 1'b0, 1'b1, 1'b0)); tick();
      check("to_adr", S_MEMADR, model(S_MEMADR, OP_LW, 1'b0, 1'b1, 1'b0));
      mem_ready = 1'b0;
      tick();
      for (int k = 1; k <= 15; k++) begin
         check("to_wait", S_MEMRD, model(S_MEMRD, OP_LW, 1'b0, 1'b0, k == 15));
         tick();
      end
      check("to_refetch", S_FETCH, model(S_FETCH, OP_LW, 1'b0, 1'b0, 1'b0));
      opcode = OP_J;
      mem_ready = 1'b1;
      #1;
      check("to_refetch_rdy", S_FETCH, model(S_FETCH, OP_J, 1'b0, 1'b1, 1'b0)); tick();
      check("to_j_dec", S_DECODE, model(S_DECODE, OP_J, 1'b0, 1'b1, 1'b0)); tick();
      check("to_j", S_JUMP, model(S_JUMP, OP_J, 1'b0, 1'b1, 1'b0)); tick();
`endif

      // Random instruction mix including illegal opcodes
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 7))
            0:       op = OP_RTYPE;
            1:       op = OP_LW;
            2:       op = OP_SW;
            3:       op = OP_BEQ;
            4:       op = OP_ADDI;
            5:       op = OP_J;
            default: op = 6'b110000 | 6'($urandom_range(0, 15));
         endcase
         run_instr("random", op, 1'($urandom_range(0, 1)));
      end
      check("final", S_FETCH, model(S_FETCH, 6'b0, 1'b0, 1'b1, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle MIPS control unit that sequences the datapath's load-enabled registers (PC, IR, MDR, A/B, ALUOut) and the register file one instruction step per state. It sits beside the datapath. It decodes the 6-bit opcode held in IR and produces every register load enable, mux select and memory strobe. An optional wait-state handshake lets fetch and data accesses stretch over slow memory.

## Interface
- MAX_WAIT, 15: maximum cycles a memory state may wait for `mem_ready` before a timeout. Used only with the wait-state feature.
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete. Ignored when the wait-state feature is compiled out.
- pc_en, ir_en, mdr_en, ab_en, aluout_en  out  1 each  register load enables
- reg_write  out  1  register-file write
- mem_read, mem_write  out  1 each  memory strobes
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- mem_timeout  out  1  one-cycle pulse when a memory wait expires
- state  out  4  current state, for debug

## Operation
- Moore FSM: all outputs decode from the registered state only.
  - Exceptions: `pc_en` in BRANCH uses `zero`; `pc_en`, `ir_en` and `mdr_en` are gated by `mem_ready` when the wait-state feature is compiled in.
- Any output not listed for a state is 0.
- Opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States and transitions:
  - FETCH: mem_read, ir_en, alu_src_b=01, pc_en, pc_src=00. Goes to DECODE.
  - DECODE: ab_en, aluout_en, alu_src_b=11. Next state by opcode:
    - lw or sw: MEMADR
    - R-type: EXEC
    - beq: BRANCH
    - addi: ADDIEX
    - j: JUMP
    - any other: FETCH, with illegal_op=1 for that cycle.
  - MEMADR: alu_src_a=1, alu_src_b=10, aluout_en. Goes to MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_read, iord, mdr_en. Goes to MEMWB.
  - MEMWB: reg_write, mem_to_reg. Goes to FETCH.
  - MEMWR: mem_write, iord. Goes to FETCH.
  - EXEC: alu_src_a=1, alu_op=10, aluout_en. Goes to ALUWB.
  - ALUWB: reg_write, reg_dst. Goes to FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero. Goes to FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, aluout_en. Goes to ADDIWB.
  - ADDIWB: reg_write. Goes to FETCH.
  - JUMP: pc_src=10, pc_en. Goes to FETCH.
- Reset:
  - State becomes FETCH.
  - Every output is 0 on the reset cycle, except those FETCH asserts from the cycle after reset deasserts.
  - Reset in any state, including mid-wait, aborts the instruction and clears the wait counter.

## Timing
- Cycles per instruction with zero wait states:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
- The enables take effect at the posedge that ends the state in which they are asserted.
- The IR opcode is valid from DECODE onward.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold until `mem_ready`=1.
  - `ir_en`, `pc_en` (in FETCH) and `mdr_en` assert only in the cycle where `mem_ready`=1.
  - The memory strobes stay high throughout the wait.
  - A wait counter counts the cycles spent waiting in the current state. If MAX_WAIT cycles pass without `mem_ready`, the FSM pulses `mem_timeout` and goes to FETCH; FETCH then restarts its access.
- `MC_MEM_WAIT_EN` undefined:
  - Every state lasts one cycle.
  - `mem_ready` is ignored.
  - `mem_timeout` is tied to 0.
  - No counter logic is built.

## Structure
- A shared package `mips_pkg` holds:
  - the opcode localparams
  - the state enum typedef (4 bits)
  - the alu_op, alu_src_b and pc_src encodings
- One sub-module is natural: `mem_wait_timer`, the wait counter with clear, enable and expired outputs. It is instantiated only under `MC_MEM_WAIT_EN`.

## Test plan
- Reset held for 3 cycles, then released:
  - All outputs are 0 during reset and state=FETCH.
  - On the first cycle after release, mem_read=1, ir_en=1, pc_en=1.
- lw opcode 100011, no waits:
  - state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - mdr_en=1 only in MEMRD; reg_write=1 and mem_to_reg=1 only in MEMWB.
- beq with zero=0, then beq with zero=1:
  - pc_en in BRANCH is 0 and then 1, with pc_src=01 and alu_op=01.
- Opcode 111111:
  - illegal_op pulses for exactly one cycle in DECODE and the next state is FETCH.
  - No reg_write or mem_write is asserted.
- With `MC_MEM_WAIT_EN`:
  - mem_ready low for 3 cycles in MEMRD: the FSM holds 4 cycles and mdr_en is high only on the 4th.
  - mem_ready held low for more than 15 cycles: mem_timeout pulses once and the FSM goes to FETCH.
- Reset asserted during MEMWR:
  - mem_write is 0 from the cycle after reset is sampled.
  - state=FETCH and the wait counter is cleared.
